// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks a word-addressed instruction memory,
// holds one fetched instruction in an output register for decode,
// honours decode backpressure, branch redirects and halts on EBREAK.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module instruction_fetch #(
    parameter logic [7:0]             RESET_ADDR  = 8'h00,
    parameter logic [`DATA_WIDTH-1:0] EBREAK_WORD = 32'h00100073
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [7:0]             imem_addr,
    input  logic [`DATA_WIDTH-1:0] imem_data,
    output logic [`DATA_WIDTH-1:0] inst_out,
    output logic [7:0]             pc_out,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    input  logic                   redirect_valid,
    input  logic [7:0]             redirect_addr,
    output logic                   halted,
    output logic [15:0]            fetch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [7:0]               pc;
    logic                     transfer;
    logic                     redirect_take;
    logic                     load;
    logic                     load_is_ebreak;

    // Decode the per-cycle control events and choose the next FSM state.
    // A redirect outranks both a normal load and an EBREAK halt; IDLE
    // ignores everything except start.
    always_comb begin
        state_next     = state;
        transfer       = inst_valid && inst_ready;
        redirect_take  = 1'b0;
        load           = 1'b0;
        load_is_ebreak = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    redirect_take = 1'b1;
                    state_next    = RUN;
                end else if (!inst_valid || inst_ready) begin
                    load           = 1'b1;
                    load_is_ebreak = (imem_data == EBREAK_WORD);
                    if (load_is_ebreak) begin
                        state_next = HALTED;
                    end
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    redirect_take = 1'b1;
                    state_next    = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch pointer: jumps on redirect, advances by one word on each load
    // (8-bit, so the top of memory wraps to word 0), otherwise holds so the
    // memory address stays stable through a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_ADDR;
        end else if (redirect_take) begin
            pc <= redirect_addr;
        end else if (load) begin
            pc <= pc + 8'd1;
        end
    end

    // Output register toward decode. A redirect flushes the held word;
    // a load captures the memory word and its address; a transfer with no
    // replacement empties the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_out   <= '0;
            pc_out     <= 8'h00;
            inst_valid <= 1'b0;
        end else if (redirect_take) begin
            inst_valid <= 1'b0;
        end else if (load) begin
            inst_out   <= imem_data;
            pc_out     <= pc;
            inst_valid <= 1'b1;
        end else if (transfer) begin
            inst_valid <= 1'b0;
        end
    end

    // Count every instruction decode actually accepted, including one that
    // is accepted on the same edge as a redirect flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'h0000;
        end else if (transfer) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == HALTED);

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_ADDR, default 8'h00: word address of the first fetch after reset.
REQ-002 Parameter EBREAK_WORD, default 32'h00100073: instruction encoding that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  leave IDLE and begin fetching.
REQ-006 imem_addr  output  8  word address to instruction_memory; combinational copy of internal pc.
REQ-007 imem_data  input  `DATA_WIDTH  instruction word returned combinationally by instruction_memory for imem_addr.
REQ-008 inst_out  output  `DATA_WIDTH  registered instruction to decode.
REQ-009 pc_out  output  8  registered word address of inst_out.
REQ-010 inst_valid  output  1  inst_out/pc_out hold a valid instruction.
REQ-011 inst_ready  input  1  decode accepts inst_out this cycle.
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_addr  input  8  target word address for redirect.
REQ-014 halted  output  1  high while in HALTED state.
REQ-015 fetch_count  output  16  count of instructions handed to decode.

Function
REQ-016 FSM states: IDLE, RUN, HALTED; encoding is free.
REQ-017 Transfer = inst_valid && inst_ready at a rising edge.
REQ-018 Load condition = state RUN && (!inst_valid || inst_ready) && !redirect_valid.
REQ-019 On load: inst_out <= imem_data; pc_out <= pc; inst_valid <= 1; pc <= pc + 1 (8-bit, 255 wraps to 0).
REQ-020 On transfer without load: inst_valid <= 0.
REQ-021 Stall (inst_valid && !inst_ready, no redirect): inst_out, pc_out, inst_valid, pc hold; imem_addr stable.
REQ-022 IDLE -> RUN at an edge with start=1; no load on that edge; first load on the following edge.
REQ-023 start is ignored in RUN and HALTED.
REQ-024 RUN -> HALTED on a load whose imem_data == EBREAK_WORD; the EBREAK word itself is loaded and delivered; pc still increments.
REQ-025 In HALTED: no loads; a pending inst_valid drains normally via transfer.
REQ-026 redirect_valid in RUN or HALTED (priority over load and halt): pc <= redirect_addr; inst_valid <= 0; state <= RUN; next load fetches redirect_addr on the following edge.
REQ-027 redirect_valid in IDLE is ignored.
REQ-028 Redirect on the same edge as a transfer: the transfer counts in fetch_count, and the output is flushed.
REQ-029 fetch_count increments by 1 on every transfer; wraps 16'hFFFF -> 0.
REQ-030 halted = (state == HALTED), combinational from state register.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, pc = RESET_ADDR, inst_out = 0, pc_out = 0, inst_valid = 0, fetch_count = 0, halted = 0.
REQ-032 Reset asserted mid-stall or mid-redirect discards all pending state; no transfer is counted at the reset edge.
REQ-033 After rst_n deasserts, the block stays in IDLE until start is sampled high.

Verification
REQ-034 Memory words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x00100073; reset, start=1 for one edge, inst_ready=1 -> inst_out sequence 0x00500093, 0x00A00113, 0x002081B3, 0x00100073 with pc_out 0..3 on consecutive cycles; then halted=1; fetch_count=4.
REQ-035 Same program, inst_ready=0 for 3 cycles after the first load -> inst_out holds 0x00500093, pc_out 0, imem_addr holds 1; after release, the sequence resumes with no skip or duplicate.
REQ-036 While at pc_out=1, redirect_valid=1 with redirect_addr=8'h03 -> next cycle inst_valid=0; following cycle inst_out=0x00100073, pc_out=3; halted follows.
REQ-037 In HALTED, redirect_addr=8'h00 -> halted=0 and the program refetches from word 0.
REQ-038 With RESET_ADDR=8'hFF and memory word 255 a non-EBREAK word -> pc_out 255 then 0 (wrap).
REQ-039 rst_n pulsed low during a stall with inst_valid=1 -> all outputs return to reset values immediately, without waiting for clk; state IDLE; fetch_count=0.
